// File: rtl/fetch_dedup_queue_if.sv
// Fetch-to-decode queue bundle: fetch-side inputs, decode handshake, and
// frontend status (stall, occupancy, stale-replay drop count).
interface fetch_dedup_queue_if #(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
);
    logic        clk_en;
    logic        flush;
    logic        in_bubble;
    logic [31:0] in_pc;
    logic [31:0] in_slot_id;
    logic [31:0] in_instr;
    logic [7:0]  in_exc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_slot_id;
    logic [31:0] out_instr;
    logic [7:0]  out_exc;
    logic        stall_out;
    logic [AW:0] count;
    logic [15:0] dup_drops;

    modport master (
        output clk_en, flush, in_bubble, in_pc, in_slot_id, in_instr, in_exc, out_ready,
        input  out_valid, out_pc, out_slot_id, out_instr, out_exc, stall_out, count, dup_drops
    );

    modport slave (
        input  clk_en, flush, in_bubble, in_pc, in_slot_id, in_instr, in_exc, out_ready,
        output out_valid, out_pc, out_slot_id, out_instr, out_exc, stall_out, count, dup_drops
    );
endinterface

// File: rtl/fetch_dedup_queue.sv
// Instruction queue between fetch and decode: drops bubbles and stale replay
// copies by wrap-safe slot id order, buffers survivors, and raises stall early.
module fetch_dedup_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input logic                clk,
    input logic                rst,
    fetch_dedup_queue_if.slave q
);
    localparam logic [AW:0] CNT_FULL  = (AW + 1)'(DEPTH);
    localparam logic [AW:0] CNT_STALL = (AW + 1)'(DEPTH - 2);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] slot_id;
        logic [31:0] instr;
        logic [7:0]  exc;
    } entry_t;

    entry_t             mem [DEPTH];
    logic [AW-1:0]      rd_ptr;
    logic [AW-1:0]      wr_ptr;
    logic [AW:0]        count_q;
    logic               have_last;
    logic [31:0]        last_slot;
    logic [15:0]        drops_q;

    logic               head_valid;
    logic               candidate;
    logic               newer;
    logic               push;
    logic               pop;
    logic               drop;
    logic signed [31:0] slot_delta;

    // Signed difference makes the ordering survive 32-bit slot id wrap.
    assign slot_delta = q.in_slot_id - last_slot;
    assign newer      = !have_last || (slot_delta > 0);
    assign head_valid = (count_q != '0);
    assign candidate  = q.clk_en && !q.flush && !q.in_bubble;
    assign pop        = q.clk_en && !q.flush && head_valid && q.out_ready;
    assign push       = candidate && newer && ((count_q != CNT_FULL) || pop);
    assign drop       = candidate && !newer;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count_q   <= '0;
            have_last <= 1'b0;
            last_slot <= '0;
            drops_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (q.clk_en) begin
            if (q.flush) begin
                rd_ptr    <= '0;
                wr_ptr    <= '0;
                count_q   <= '0;
                have_last <= 1'b0;
            end else begin
                if (push) begin
                    mem[wr_ptr] <= {q.in_pc, q.in_slot_id, q.in_instr, q.in_exc};
                    wr_ptr      <= wr_ptr + AW'(1);
                    last_slot   <= q.in_slot_id;
                    have_last   <= 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                if (push && !pop) begin
                    count_q <= count_q + (AW + 1)'(1);
                end else if (pop && !push) begin
                    count_q <= count_q - (AW + 1)'(1);
                end
                // A full-queue refusal is not a drop: replay will bring it back.
                if (drop && (drops_q != 16'hFFFF)) begin
                    drops_q <= drops_q + 16'd1;
                end
            end
        end
    end

    assign q.out_valid   = head_valid;
    assign q.out_pc      = mem[rd_ptr].pc;
    assign q.out_slot_id = mem[rd_ptr].slot_id;
    assign q.out_instr   = mem[rd_ptr].instr;
    assign q.out_exc     = mem[rd_ptr].exc;
    assign q.stall_out   = (count_q >= CNT_STALL);
    assign q.count       = count_q;
    assign q.dup_drops   = drops_q;
endmodule

// File: doc/fetch_dedup_queue.md
# fetch_dedup_queue

Frontend instruction queue between the last fetch pipe stage and decode. It takes the fetch stream of PC, slot id, instruction word and exception code, and drops bubbles and stale replay copies by comparing slot ids in monotonic, wrap-safe order. Surviving instructions are buffered in a small FIFO and presented to decode with a valid/ready handshake. It also produces the backpressure stall that drives the frontend replay mechanism.

## Interface
- DEPTH, 4, FIFO entries; power of two, at least 4
- AW, 2, log2(DEPTH)
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- clk_en  in  1  global clock enable; when low, all state holds
- flush  in  1  redirect/exception flush from backend
- in_bubble  in  1  fetch slot carries no instruction
- in_pc  in  32  fetch PC
- in_slot_id  in  32  frontend slot id
- in_instr  in  32  instruction word aligned with in_pc
- in_exc  in  8  fetch exception code; 0 means none
- out_valid  out  1  head entry is valid
- out_ready  in  1  decode consumes head this cycle
- out_pc  out  32  head PC
- out_slot_id  out  32  head slot id
- out_instr  out  32  head instruction
- out_exc  out  8  head exception code
- stall_out  out  1  backpressure to frontend
- count  out  AW+1  occupancy
- dup_drops  out  16  saturating count of stale replays discarded

## Operation
- Newer test: in_slot_id is newer when the signed 32-bit difference (in_slot_id - last_slot) is greater than 0, or when have_last = 0.
- Candidate: clk_en && !flush && !in_bubble.
- A candidate that is not newer is discarded; dup_drops increments, saturating at 16'hFFFF.
- A newer candidate is pushed when count < DEPTH, or when a pop occurs in the same cycle. On push, last_slot <= in_slot_id and have_last <= 1.
- A newer candidate that arrives while the queue is full with no pop is not pushed. last_slot is unchanged and dup_drops is not incremented, so the frontend replay re-supplies it later.
- Pop: clk_en && out_valid && out_ready. The read pointer advances.
- A nonzero in_exc entry is queued like any other entry. This block does not act on exceptions.
- Flush takes priority over push and pop:
  - count, pointers and have_last are cleared.
  - Input in the flush cycle is ignored.
  - dup_drops is retained.
- stall_out = (count >= DEPTH-2). This is combinational from registered count and leaves 2 entries of slack for in-flight fetch work.
- out_valid = (count != 0). Head fields come combinationally from storage[rd_ptr]. When out_valid = 0, head fields are don't-care.
- Pointers are AW bits and wrap modulo DEPTH. count is AW+1 bits.

## Timing
- Reset (async) sets: count 0, rd_ptr/wr_ptr 0, have_last 0, last_slot 0, dup_drops 0, out_valid 0, stall_out 0, all storage 0, so head fields read 0.
- Latency: an input pushed at edge N drives out_valid = 1 and the head fields after edge N, when the queue was empty.
- No bypass: the input never reaches out_* in the same cycle.
- Simultaneous push and pop: count is unchanged. Legal at full, where the freed slot is reused.
- Simultaneous push and pop at count = 1: the new entry becomes head after the edge.
- Slot id wrap: 32'hFFFFFFFF followed by 32'h0 is newer and is pushed.
- clk_en low: no push, pop or counter update regardless of other inputs.
- Reset deasserted mid-stream: the first non-bubble slot is accepted unconditionally because have_last = 0.

## Test plan
- Reset, then feed slots 0,1,2 with PC 0x400/0x404/0x408 and out_ready = 1. Required: out_valid rises one cycle after the first push; head PCs appear in order; count never exceeds 1; dup_drops = 0.
- Replay stream of slot ids 5,6,7,5,6,7,8, each non-bubble. Required: only 5,6,7,8 are dequeued; dup_drops = 3.
- Hold out_ready = 0 and feed slots 10..15 with DEPTH = 4. Required:
  - stall_out goes to 1 after count reaches 2.
  - Slots 10–13 are queued and count = 4.
  - Slots 14 and 15 are not queued and dup_drops is unchanged.
  - Resume, then replay 14,15. Required: both are queued.
- With count = 3, assert flush while a new slot 20 is presented. Required: count = 0 and out_valid = 0 after the edge. Then slot 3 is accepted, proving have_last was cleared.
- Feed slot 32'hFFFFFFFE, 32'hFFFFFFFF, then 0 and 1. Required: all four are dequeued in order with no drops.
- Feed bubbles with slot ids 30,31, then a non-bubble slot 30 with in_exc = 8'h84. Required: the entry is queued with out_exc = 8'h84 and dup_drops = 0.
